// File: rtl/dsp_mult_arbiter_if.sv
// Requester, result and multiplier-side signals of the shared 16x16 multiplier arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the attached multiplier.
interface dsp_mult_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][15:0] req_a;
    logic [NREQ-1:0][15:0] req_b;
    logic [NREQ-1:0]       res_valid;
    logic [IDW-1:0]        res_id;
    logic [31:0]           res_x;
    logic [15:0]           mult_a;
    logic [15:0]           mult_b;
    logic [31:0]           mult_x;

    modport slave (
        input  req_valid, req_a, req_b, mult_x,
        output req_ready, res_valid, res_id, res_x, mult_a, mult_b
    );

    modport master (
        output req_valid, req_a, req_b, mult_x,
        input  req_ready, res_valid, res_id, res_x, mult_a, mult_b
    );
endinterface

// File: rtl/dsp_mult_arbiter.sv
// Shares one external 16x16 multiplier among NREQ requesters; owner tags ride alongside the product.
// Define MULT_ARB_FIXED_PRI_EN for fixed lowest-index priority instead of round-robin.
module dsp_mult_arbiter #(
    parameter int NREQ         = 4,
    parameter int MULT_LATENCY = 1
) (
    input logic              clock,
    input logic              reset,
    dsp_mult_arbiter_if.slave bus
);
    localparam int IDW    = $clog2(NREQ);
    localparam int STAGES = MULT_LATENCY;

    logic                      gnt_vld;
    logic [IDW-1:0]            gnt_id;
    logic                      hs;
    logic [STAGES:0]           vld_pipe;
    logic [STAGES:0][IDW-1:0]  id_pipe;

`ifdef MULT_ARB_FIXED_PRI_EN
    // Descending scan so the lowest valid index is the last one written.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] last;
    logic [IDW-1:0] rr_idx;

    // Scan offsets NREQ..1 from last; the smallest offset (closest after last) wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        rr_idx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            rr_idx = IDW'((int'(last) + k) % NREQ);
            if (bus.req_valid[rr_idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = rr_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)   last <= IDW'(NREQ - 1);
        else if (hs) last <= gnt_id;
    end
`endif

    assign hs            = gnt_vld & ~reset;
    assign bus.req_ready = hs ? (NREQ'(1) << gnt_id) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe      <= '0;
            id_pipe       <= '0;
            bus.mult_a    <= '0;
            bus.mult_b    <= '0;
            bus.res_valid <= '0;
            bus.res_id    <= '0;
            bus.res_x     <= '0;
        end else begin
            vld_pipe[0] <= hs;
            id_pipe[0]  <= gnt_id;
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                id_pipe[k]  <= id_pipe[k-1];
            end
            if (hs) begin
                bus.mult_a <= bus.req_a[gnt_id];
                bus.mult_b <= bus.req_b[gnt_id];
            end
            // Tag at the last stage lines up with the product on mult_x this cycle.
            bus.res_valid <= vld_pipe[STAGES] ? (NREQ'(1) << id_pipe[STAGES]) : '0;
            if (vld_pipe[STAGES]) begin
                bus.res_id <= id_pipe[STAGES];
                bus.res_x  <= bus.mult_x;
            end
        end
    end
endmodule

// File: tb/tb_dsp_mult_arbiter.sv
// Bench for dsp_mult_arbiter: directed scenarios plus random traffic against a queue-based model.
// Honours MULT_ARB_FIXED_PRI_EN when the build defines it.
module tb_dsp_mult_arbiter;
    localparam int NREQ = 4;
    localparam int ML   = 1;
    localparam int IDW  = $clog2(NREQ);

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dsp_mult_arbiter_if #(.NREQ(NREQ)) bus();

    dsp_mult_arbiter #(.NREQ(NREQ), .MULT_LATENCY(ML)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Attached multiplier: ML register stages of the unsigned product.
    logic [31:0] mpipe [ML];
    always @(posedge clock) begin
        mpipe[0] <= 32'(bus.mult_a) * 32'(bus.mult_b);
        for (int k = 1; k < ML; k++) mpipe[k] <= mpipe[k-1];
    end
    assign bus.mult_x = mpipe[ML-1];

    typedef struct {
        int          id;
        logic [31:0] x;
        int          due;
    } exp_t;

    exp_t            q[$];
    int              gnt_log[$];
    logic [31:0]     res_log[$];
    int              m_last = NREQ - 1;
    logic [15:0]     e_ma = '0, e_mb = '0;
    bit              post_rst = 1'b0;
    logic [NREQ-1:0] hs_mask = '0;
    int              cyc = 0;
    int              n_vec = 0;
    int              n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        int j;
`ifdef MULT_ARB_FIXED_PRI_EN
        for (int i = 0; i < NREQ; i++) begin
            j = i;
            if (v[j[IDW-1:0]]) return i;
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            j = (last + k) % NREQ;
            if (v[j[IDW-1:0]]) return j;
        end
`endif
        return -1;
    endfunction

    // Called once per cycle, away from the clock edge.
    task automatic check_cycle();
        int              w;
        logic [IDW-1:0]  wi;
        logic [NREQ-1:0] er;
        hs_mask = '0;
        if (reset) begin
            chk("ready_in_reset", bus.req_ready, 0);
            q.delete();
            m_last   = NREQ - 1;
            e_ma     = '0;
            e_mb     = '0;
            post_rst = 1'b1;
            return;
        end
        if (post_rst) begin
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_res_id", bus.res_id, 0);
            chk("rst_res_x", bus.res_x, 0);
            post_rst = 1'b0;
        end
        chk("mult_a", bus.mult_a, e_ma);
        chk("mult_b", bus.mult_b, e_mb);
        w  = pick(bus.req_valid, m_last);
        wi = IDW'(w);
        er = (w < 0) ? '0 : (NREQ'(1) << wi);
        chk("req_ready", bus.req_ready, er);
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("res_valid", bus.res_valid, NREQ'(1) << q[0].id);
            chk("res_id", bus.res_id, q[0].id);
            chk("res_x", bus.res_x, q[0].x);
            res_log.push_back(bus.res_x);
            void'(q.pop_front());
        end else begin
            chk("res_valid_idle", bus.res_valid, 0);
        end
        if (w >= 0) begin
            q.push_back('{id: w, x: 32'(bus.req_a[wi]) * 32'(bus.req_b[wi]), due: cyc + ML + 2});
            e_ma    = bus.req_a[wi];
            e_mb    = bus.req_b[wi];
            m_last  = w;
            hs_mask = er;
            gnt_log.push_back(w);
        end
    endtask

    task automatic step();
        @(negedge clock);
        check_cycle();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        gnt_log.delete();
        res_log.delete();
    endtask

    task automatic newop(input int i);
        logic [IDW-1:0] ii;
        ii = IDW'(i);
        bus.req_valid[ii] = 1'b1;
        bus.req_a[ii] = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
        bus.req_b[ii] = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
    endtask

    task automatic drain(input int n);
        clear_reqs();
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int e;
        clear_reqs();
        do_reset();

        // Single request from requester 0: 200 * 3.
        bus.req_valid = 4'b0001;
        bus.req_a[0] = 16'd200;
        bus.req_b[0] = 16'd3;
        #1;
        chk("single_ready", bus.req_ready, 4'b0001);
        step();
        clear_reqs();
        step();
        step();
        chk("single_res_valid", bus.res_valid, 4'b0001);
        chk("single_res_x", bus.res_x, 32'd600);
        chk("single_res_id", bus.res_id, 0);
        drain(3);

        // Saturation: all requesters valid, A=i+1, B=1000.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = 1'b1;
            bus.req_a[i]     = 16'(i + 1);
            bus.req_b[i]     = 16'd1000;
        end
        for (int k = 0; k < 12; k++) step();
        drain(4);
        chk("sat_gnt_len", gnt_log.size() >= 8, 1);
        chk("sat_res_len", res_log.size() >= 4, 1);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
`ifdef MULT_ARB_FIXED_PRI_EN
            e = 0;
`else
            e = i % NREQ;
`endif
            chk("sat_gnt", gnt_log[i], e);
        end
        for (int i = 0; i < 4 && i < res_log.size(); i++) begin
`ifdef MULT_ARB_FIXED_PRI_EN
            e = 1000;
`else
            e = 1000 * (i + 1);
`endif
            chk("sat_res_x", res_log[i], e);
        end

        // Requesters 1 and 3 only.
        do_reset();
        bus.req_valid = 4'b1010;
        bus.req_a[1] = 16'd11; bus.req_b[1] = 16'd2;
        bus.req_a[3] = 16'd13; bus.req_b[3] = 16'd2;
        for (int k = 0; k < 6; k++) step();
        drain(4);
        chk("wrap_len", gnt_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
`ifdef MULT_ARB_FIXED_PRI_EN
            e = 1;
`else
            e = (i % 2 == 0) ? 1 : 3;
`endif
            chk("wrap_gnt", gnt_log[i], e);
        end

        // Requesters 0 and 2, then requester 0 drops out.
        do_reset();
        bus.req_valid = 4'b0101;
        bus.req_a[0] = 16'd7; bus.req_b[0] = 16'd9;
        bus.req_a[2] = 16'd8; bus.req_b[2] = 16'd9;
        for (int k = 0; k < 4; k++) step();
        bus.req_valid[0] = 1'b0;
        step();
        drain(4);
        chk("pri_len", gnt_log.size(), 5);
        for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
`ifdef MULT_ARB_FIXED_PRI_EN
            e = (i < 4) ? 0 : 2;
`else
            e = (i == 4) ? 2 : ((i % 2 == 0) ? 0 : 2);
`endif
            chk("pri_gnt", gnt_log[i], e);
        end

        // Reset one cycle after a handshake discards the operation.
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_a[0] = 16'd5; bus.req_b[0] = 16'd7;
        step();
        clear_reqs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_mult_a", bus.mult_a, 0);
        chk("midrst_mult_b", bus.mult_b, 0);
        for (int k = 0; k < 5; k++) begin
            chk("midrst_no_res", bus.res_valid, 0);
            step();
        end

        // Operand extremes.
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_a[1] = 16'hFFFF; bus.req_b[1] = 16'hFFFF;
        step();
        bus.req_a[1] = 16'h0000; bus.req_b[1] = 16'hFFFF;
        step();
        drain(4);
        chk("ext_len", res_log.size(), 2);
        if (res_log.size() == 2) begin
            chk("ext_max", res_log[0], 32'hFFFE0001);
            chk("ext_zero", res_log[1], 32'h0);
        end

        // Random traffic with withdrawals and one reset mid-stream.
        do_reset();
        clear_reqs();
        hs_mask = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && hs_mask[i]) begin
                    if ($urandom_range(9) < 7) newop(i);
                    else bus.req_valid[i] = 1'b0;
                end else if (bus.req_valid[i]) begin
                    if ($urandom_range(19) == 0) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(9) < 4) begin
                    newop(i);
                end
            end
            reset = (n == 250);
            step();
        end
        reset = 1'b0;
        drain(6);
        chk("drain_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
